// File: rtl/tone_decoder.sv
// tone_decoder: recovers the key scan code from a square-wave tone by timing
// the half-periods, matching them against the note table, and locking after
// CONFIRM consecutive agreeing measurements.
module tone_decoder #(
  parameter int TOL     = 1000,
  parameter int CONFIRM = 4,
  parameter int TIMEOUT = 400000,
  // Nominal half-periods (interval minus 1); entry i pairs with NOTE_CODE[i].
  parameter logic [6:0][19:0] NOTE_M = {20'd101239, 20'd113636, 20'd127551,
                                        20'd143172, 20'd151689, 20'd170264,
                                        20'd191116}
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pwm_in,
  output logic [7:0]  scan_out,
  output logic        valid,
  output logic        locked,
  output logic [19:0] half_period_meas
);

  localparam logic [6:0][7:0] NOTE_CODE = {8'h21, 8'h4B, 8'h1B, 8'h2B,
                                           8'h3A, 8'h2D, 8'h23};
  localparam int          CW        = $clog2(CONFIRM + 1);
  localparam logic [CW-1:0] CONFIRM_W = CW'(CONFIRM);
  localparam logic [19:0] TOL_W     = 20'(TOL);
  localparam logic [19:0] TIMEOUT_W = 20'(TIMEOUT);

  typedef enum logic [1:0] {ST_SILENT, ST_ACQUIRE, ST_LOCKED} state_t;

  state_t          state, state_d;
  logic            sync1, sync2, sync3, edge_strobe;
  logic [19:0]     cnt;
  logic [19:0]     meas;
  logic [7:0]      match_code;
  logic            timeout;
  logic [7:0]      cand, cand_d;
  logic [CW-1:0]   mcnt, mcnt_d;
  logic [7:0]      scan_d;
  logic            valid_d;
  logic [19:0]     meas_d;

  // Two-flop synchronizer, then a registered edge detector (either polarity).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1       <= 1'b0;
      sync2       <= 1'b0;
      sync3       <= 1'b0;
      edge_strobe <= 1'b0;
    end else begin
      sync1       <= pwm_in;
      sync2       <= sync1;
      sync3       <= sync2;
      edge_strobe <= sync2 ^ sync3;
    end
  end

  // Interval counter: restarts at 1 after each strobe, parks at TIMEOUT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               cnt <= '0;
    else if (edge_strobe)     cnt <= 20'd1;
    else if (cnt != TIMEOUT_W) cnt <= cnt + 20'd1;
  end

  // cnt never exceeds TIMEOUT (< 2^20), so M = cnt-1 always fits in 20 bits.
  assign meas    = (cnt == '0) ? '0 : cnt - 20'd1;
  assign timeout = (state != ST_SILENT) && !edge_strobe && (cnt == TIMEOUT_W);

  // Table lookup: table gaps exceed 2*TOL, so at most one entry can hit.
  always_comb begin
    logic [19:0] diff;
    match_code = '0;
    diff       = '0;
    for (int i = 0; i < 7; i++) begin
      diff = (meas >= NOTE_M[i]) ? meas - NOTE_M[i] : NOTE_M[i] - meas;
      if (diff <= TOL_W) match_code = NOTE_CODE[i];
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_SILENT;
    else        state <= state_d;
  end

  // Next state; an edge always takes priority over a timeout.
  always_comb begin
    state_d = state;
    case (state)
      ST_SILENT:  if (edge_strobe) state_d = ST_ACQUIRE;
      ST_ACQUIRE: begin
        if (edge_strobe) begin
          if (mcnt_d == CONFIRM_W) state_d = ST_LOCKED;
        end else if (timeout) state_d = ST_SILENT;
      end
      ST_LOCKED: begin
        if (edge_strobe) begin
          if (match_code != cand) state_d = ST_ACQUIRE;
        end else if (timeout) state_d = ST_SILENT;
      end
      default: state_d = ST_SILENT;
    endcase
  end

  // Output/datapath next values: candidate tracking, scan load and valid pulse.
  always_comb begin
    cand_d  = cand;
    mcnt_d  = mcnt;
    scan_d  = scan_out;
    valid_d = 1'b0;
    meas_d  = half_period_meas;
    if (edge_strobe && state != ST_SILENT) begin
      meas_d = meas;
      if (match_code == '0) begin
        mcnt_d = '0;
      end else if (match_code == cand) begin
        if (mcnt != CONFIRM_W) mcnt_d = mcnt + CW'(1);
      end else begin
        cand_d = match_code;
        mcnt_d = CW'(1);
      end
      // A fresh lock only announces itself when the code actually changes.
      if (state == ST_ACQUIRE && mcnt_d == CONFIRM_W && cand_d != scan_out) begin
        scan_d  = cand_d;
        valid_d = 1'b1;
      end
    end else if (timeout) begin
      mcnt_d = '0;
      if (scan_out != '0) begin
        scan_d  = '0;
        valid_d = 1'b1;
      end
    end
  end

  // Registered outputs and candidate tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand             <= '0;
      mcnt             <= '0;
      scan_out         <= '0;
      valid            <= 1'b0;
      locked           <= 1'b0;
      half_period_meas <= '0;
    end else begin
      cand             <= cand_d;
      mcnt             <= mcnt_d;
      scan_out         <= scan_d;
      valid            <= valid_d;
      locked           <= (state_d == ST_LOCKED);
      half_period_meas <= meas_d;
    end
  end

endmodule
